serial_alu_seq: RTL and testbench
=================================

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the operand length in bits, legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1: a request is offered.
REQ-005 The block SHALL have port in_ready, output, 1: the block can accept a request.
REQ-006 The block SHALL have ports op_a and op_b, input, WIDTH each: the parallel operands.
REQ-007 The block SHALL have port op_func, input, 3: the function code forwarded to the serial ALU.
REQ-008 The block SHALL have port res_valid, output, 1: a result is held.
REQ-009 The block SHALL have port res_ready, input, 1: the consumer takes the result.
REQ-010 The block SHALL have port res_data, output, WIDTH: the assembled result.
REQ-011 The block SHALL have port res_carry, output, 1: the final ALU carry.
REQ-012 The block SHALL have ports alu_a and alu_b, output, 1 each: the serial operand bits to the ALU.
REQ-013 The block SHALL have port alu_func, output, 3: the function code to the ALU.
REQ-014 The block SHALL have port alu_rst, output, 1: the ALU's synchronous active-low carry clear.
REQ-015 The block SHALL have port alu_out, input, 1: the ALU's combinational result bit.
REQ-016 The block SHALL have port alu_c_out, input, 1: the ALU's registered carry.

Function
REQ-017 The state machine SHALL have exactly four states: IDLE, CLEAR, SHIFT, HOLD.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 An in_valid && in_ready edge SHALL latch op_a, op_b and op_func, and go IDLE->CLEAR.
REQ-020 In IDLE and CLEAR, alu_rst SHALL be 0, and alu_a, alu_b and alu_func SHALL be 0.
REQ-021 CLEAR SHALL last exactly one cycle and then go to SHIFT with bit counter = 0.
REQ-022 In SHIFT cycle k (0..WIDTH-1), the block SHALL drive alu_a = a[k], alu_b = b[k], alu_func = latched func and alu_rst = 1.
REQ-023 In SHIFT cycle k, the block SHALL capture alu_out into res_data[k] at the closing edge, LSB-first.
REQ-024 The counter SHALL be clog2(WIDTH) bits wide, compare against WIDTH-1 to end SHIFT, and never wrap.
REQ-025 On entry to HOLD, the block SHALL sample alu_c_out into res_carry and set res_valid = 1.
REQ-026 Latency from accept edge to res_valid SHALL be exactly WIDTH+2 cycles.
REQ-027 The block SHALL stay in HOLD with res_data and res_carry stable until res_valid && res_ready, then return to IDLE.
REQ-028 If res_ready is already high on entry to HOLD, the block SHALL hold res_valid for exactly one cycle.
REQ-029 in_valid asserted outside IDLE SHALL be ignored (no accept, no state change).
REQ-030 In HOLD, alu_rst SHALL be 0 so the ALU carry is cleared before the next request.
REQ-031 The returned IDLE cycle SHALL accept a new request, giving back-to-back throughput of one request per WIDTH+3 cycles.

Reset
REQ-032 On rst = 0, the block SHALL go to IDLE asynchronously.
REQ-033 On rst = 0, res_valid, res_data, res_carry and the counter SHALL be 0, alu_rst SHALL be 0, and in_ready SHALL be 1 after release.
REQ-034 Reset mid-SHIFT or mid-HOLD SHALL discard the operation, with no res_valid after release.

Structure
REQ-035 The state encoding and a 3-bit func constant set (F_XOR=000, F_ADD=010, F_AND=100) SHALL live in the shared package serial_cpu_pkg.
REQ-036 The block SHALL have exactly one sub-module, piso_shreg, a WIDTH-bit parallel-load shift-right register, instanced twice for op_a and op_b.
REQ-037 The result SHALL be assembled in place in a local register; the ALU SHALL stay external.

Verification (bench pairs the block with the team's bit-serial ALU, WIDTH=8)
REQ-038 The bench SHALL cover: F_ADD, a=0x5A, b=0x3C -> res_data=0x96, res_carry=0, res_valid at cycle 10 after accept.
REQ-039 The bench SHALL cover: F_ADD, a=0xFF, b=0x01 -> res_data=0x00, res_carry=1.
REQ-040 The bench SHALL cover: F_XOR 0x5A/0x3C -> 0x66, then F_AND same operands -> 0x18, with back-to-back requests and res_ready tied high, accepted 11 cycles apart.
REQ-041 The bench SHALL cover: res_ready held low for 5 cycles in HOLD -> res_data stable and in_ready 0, and a second in_valid ignored.
REQ-042 The bench SHALL cover: rst pulsed low in SHIFT cycle 3 -> immediate IDLE with all outputs 0, then a fresh F_ADD 0x01+0x01 -> 0x02, res_carry=0.

Source files
------------

// File: rtl/serial_cpu_pkg.sv
// Shared definitions for the bit-serial CPU slice: sequencer states and ALU function codes.
package serial_cpu_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } seq_state_e;

  // Function codes understood by the bit-serial ALU.
  localparam logic [2:0] F_XOR = 3'b000;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_AND = 3'b100;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register: loads a word, then presents it LSB-first.
module piso_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] data_q;

  // Load has priority over shift; shifting moves toward bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign dout = data_q[0];

endmodule

// File: rtl/serial_alu_seq.sv
// Sequencer that feeds parallel operands bit-serially through an external ALU
// and assembles the LSB-first result stream back into a parallel word.
module serial_alu_seq
  import serial_cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  // Request side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_func,
  // Result side
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  // External serial ALU
  output logic             alu_a,
  output logic             alu_b,
  output logic [2:0]       alu_func,
  output logic             alu_rst,
  input  logic             alu_out,
  input  logic             alu_c_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       func_q;
  logic [WIDTH-1:0] res_data_q;
  logic             carry_q;
  logic             hold_first_q;
  logic             load;
  logic             shift;
  logic             sa_bit;
  logic             sb_bit;

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (op_a),
    .dout  (sa_bit)
  );

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (op_b),
    .dout  (sb_bit)
  );

  // State, counter, latched function and in-place result assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      func_q       <= 3'b000;
      res_data_q   <= '0;
      carry_q      <= 1'b0;
      hold_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_first_q <= (state_q == StShift) && (state_d == StHold);
      if (load) begin
        func_q <= op_func;
      end
      if (state_q == StShift) begin
        res_data_q[cnt_q] <= alu_out;
      end
      // The ALU carry is cleared at the first HOLD edge, so freeze it here.
      if (hold_first_q) begin
        carry_q <= alu_c_out;
      end
    end
  end

  // Next-state, counter and ALU-side drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_func = 3'b000;
    alu_rst  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        alu_a    = sa_bit;
        alu_b    = sb_bit;
        alu_func = func_q;
        alu_rst  = 1'b1;
        shift    = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and result outputs; the first HOLD cycle shows the live ALU carry.
  always_comb begin
    in_ready  = (state_q == StIdle);
    res_valid = (state_q == StHold);
    res_data  = res_data_q;
    res_carry = hold_first_q ? alu_c_out : carry_q;
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq paired with a behavioural bit-serial ALU.
module tb_serial_alu_seq;
  import serial_cpu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   op_func;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic         alu_a;
  logic         alu_b;
  logic [2:0]   alu_func;
  logic         alu_rst;
  logic         alu_out;
  logic         alu_c_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_func   (op_func),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_rst   (alu_rst),
    .alu_out   (alu_out),
    .alu_c_out (alu_c_out)
  );

  // Behavioural bit-serial ALU: combinational result bit, registered carry.
  always_comb begin
    alu_out = 1'b0;
    case (alu_func)
      F_XOR:   alu_out = alu_a ^ alu_b;
      F_ADD:   alu_out = alu_a ^ alu_b ^ alu_c_out;
      F_AND:   alu_out = alu_a & alu_b;
      default: alu_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_c_out <= 1'b0;
    end else if (!alu_rst) begin
      alu_c_out <= 1'b0;
    end else if (alu_func == F_ADD) begin
      alu_c_out <= (alu_a & alu_b) | (alu_a & alu_c_out) | (alu_b & alu_c_out);
    end else begin
      alu_c_out <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one request at a negedge; returns at the negedge after the accept edge.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    op_a     = a;
    op_b     = b;
    op_func  = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Step negedges until res_valid, bounded; cyc counts cycles since the accept edge.
  task automatic wait_res(input int start, output int cyc);
    cyc = start;
    while (res_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int highs;

    rst       = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_func   = 3'b000;
    res_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_carry", 64'(res_carry), 64'd0);
    chk("rst_alu_rst", 64'(alu_rst), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ADD 0x5A + 0x3C with res_ready already high
    chk("t1_ready_before", 64'(in_ready), 64'd1);
    offer(8'h5A, 8'h3C, F_ADD);
    chk("t1_clear_alu_rst", 64'(alu_rst), 64'd0);
    chk("t1_clear_alu_func", 64'(alu_func), 64'd0);
    chk("t1_clear_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_k0_alu_rst", 64'(alu_rst), 64'd1);
    chk("t1_k0_alu_func", 64'(alu_func), 64'(F_ADD));
    chk("t1_k0_bits", 64'({alu_a, alu_b}), 64'b00);
    @(negedge clk);
    chk("t1_k1_bits", 64'({alu_a, alu_b}), 64'b10);
    wait_res(3, cyc);
    chk("t1_latency", 64'(cyc), 64'd10);
    chk("t1_data", 64'(res_data), 64'h96);
    chk("t1_carry", 64'(res_carry), 64'd0);
    chk("t1_hold_alu_rst", 64'(alu_rst), 64'd0);
    @(negedge clk);
    chk("t1_valid_one_cycle", 64'(res_valid), 64'd0);
    chk("t1_back_idle", 64'(in_ready), 64'd1);

    // ADD 0xFF + 0x01 with a 5-cycle stall and an ignored request during HOLD
    res_ready = 1'b0;
    offer(8'hFF, 8'h01, F_ADD);
    wait_res(1, cyc);
    chk("t2_latency", 64'(cyc), 64'd10);
    chk("t2_data", 64'(res_data), 64'h00);
    chk("t2_carry", 64'(res_carry), 64'd1);
    op_a     = 8'h11;
    op_b     = 8'h22;
    op_func  = F_AND;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", 64'(res_valid), 64'd1);
      chk("t2_stall_data", 64'(res_data), 64'h00);
      chk("t2_stall_carry", 64'(res_carry), 64'd1);
      chk("t2_stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_valid", 64'(res_valid), 64'd0);
    chk("t2_release_ready", 64'(in_ready), 64'd1);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) highs++;
    end
    chk("t2_no_phantom_op", 64'(highs), 64'd0);

    // Back-to-back XOR then AND with res_ready tied high
    op_a     = 8'h5A;
    op_b     = 8'h3C;
    op_func  = F_XOR;
    in_valid = 1'b1;
    @(negedge clk);
    op_func = F_AND;
    wait_res(1, cyc);
    chk("t3_xor_latency", 64'(cyc), 64'd10);
    chk("t3_xor_data", 64'(res_data), 64'h66);
    chk("t3_xor_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t3_idle_at_11", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_second_accepted", 64'(in_ready), 64'd0);
    wait_res(1, cyc);
    chk("t3_and_latency", 64'(cyc), 64'd10);
    chk("t3_and_data", 64'(res_data), 64'h18);
    chk("t3_and_carry", 64'(res_carry), 64'd0);
    @(negedge clk);

    // Reset pulsed in SHIFT cycle 3, then a fresh request
    offer(8'hFF, 8'hFF, F_ADD);
    repeat (4) @(negedge clk);
    chk("t4_in_shift", 64'(alu_rst), 64'd1);
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", 64'(res_valid), 64'd0);
    chk("t4_rst_data", 64'(res_data), 64'd0);
    chk("t4_rst_carry", 64'(res_carry), 64'd0);
    chk("t4_rst_alu_rst", 64'(alu_rst), 64'd0);
    chk("t4_rst_alu_bits", 64'({alu_a, alu_b, alu_func}), 64'd0);
    chk("t4_rst_idle", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) highs++;
    end
    chk("t4_discarded", 64'(highs), 64'd0);
    chk("t4_ready_after", 64'(in_ready), 64'd1);
    offer(8'h01, 8'h01, F_ADD);
    wait_res(1, cyc);
    chk("t4_latency", 64'(cyc), 64'd10);
    chk("t4_data", 64'(res_data), 64'h02);
    chk("t4_carry", 64'(res_carry), 64'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
